// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth signed multiplier.
// Takes one operand pair over a valid/ready handshake. The multiplier is
// scanned two bits per cycle, and each overlapping triplet is recoded into a
// digit in {-2,-1,0,+1,+2}. The exact 2*WIDTH-bit product is returned over a
// valid/ready handshake.
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH/2) + 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q,   state_d;
  logic [PW-1:0]         a_q,       a_d;        // sign-extended multiplicand
  logic signed [WIDTH:0] scan_q,    scan_d;     // {b, b[-1]} shifted right by 2 each step
  logic [PW-1:0]         acc_q,     acc_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [PW-1:0]         product_q, product_d;
  logic [PW-1:0]         pp;

  // Booth recoding of the current triplet into a 2*WIDTH-bit partial product.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pp = '0;
    unique case (scan_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;      // 000, 111
    endcase
  end

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    scan_d    = scan_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{WIDTH{a[WIDTH-1]}}, a};
          scan_d  = {b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Digit i carries weight 4^i, so the partial product is shifted by 2*cnt.
        acc_d  = acc_q + (pp << {cnt_q, 1'b0});
        scan_d = scan_q >>> 2;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE: begin
        // A new in_valid here is ignored; operands are taken only once back in IDLE.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      scan_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      a_q       <= a_d;
      scan_q    <= scan_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult (WIDTH=8).
// The reference is the plain signed product a*b.
module tb_booth_r4_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;

  booth_r4_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count handshakes on both sides.
  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)   n_acc++;
      if (out_valid && out_ready) n_out++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = $signed(x) * $signed(y);
    return p[2*W-1:0];
  endfunction

  // Runs one multiplication. Entry and exit are #1 after a rising edge.
  // stall: cycles with out_ready=0 after out_valid. poke: drive junk in_valid while busy.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int stall, input bit poke, input bit full);
    logic [2*W-1:0] exp_p;
    int lat;
    int busy_n;
    exp_p = ref_mul(xa, xb);
    if (full) check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = poke; a = W'($urandom); b = W'($urandom);
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
      if (poke) begin a = W'($urandom); b = W'($urandom); end
    end
    if (!out_valid) begin
      check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (full) begin
      check("latency", lat, W/2);
      check("busy_cycles", busy_n, W/2);
    end
    check("product", {16'd0, product}, {16'd0, exp_p});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (full) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_product", {16'd0, product}, {16'd0, exp_p});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (full) begin
      check("back_idle_ready", {31'd0, in_ready}, 32'd1);
      check("back_idle_valid", {31'd0, out_valid}, 32'd0);
      check("product_kept", {16'd0, product}, {16'd0, exp_p});
    end
  endtask

  initial begin
    int acc0;
    int out0;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_product",   {16'd0, product},   32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(8'd3,    8'd5,    0, 1'b0, 1'b1);
    run_op(8'hF9,   8'd6,    0, 1'b0, 1'b1);
    run_op(8'd127,  8'h80,   0, 1'b0, 1'b1);
    run_op(8'h80,   8'h80,   0, 1'b0, 1'b1);
    run_op(8'd0,    8'hFF,   0, 1'b0, 1'b1);
    // Backpressure plus ignored in_valid during RUN/DONE and at the DONE exit edge.
    run_op(8'h95,   8'h3B,   5, 1'b1, 1'b1);

    // Reset during the second RUN cycle.
    a = 8'd100; b = 8'd77; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy",      {31'd0, busy},      32'd0);
    check("midrst_product",   {16'd0, product},   32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    run_op(8'hFF, 8'hFF, 0, 1'b0, 1'b1);

    // Randomized pairs with random stalls and junk in_valid while busy.
    acc0 = n_acc; out0 = n_out;
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom); rb = W'($urandom);
      if (k < 4) begin ra = (k < 2) ? 8'h80 : 8'h7F; rb = (k % 2 == 0) ? 8'h80 : 8'h7F; end
      run_op(ra, rb, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0);
    end
    check("accepted_count", n_acc - acc0, 1000);
    check("delivered_count", n_out - out0, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Iterative radix-4 Booth signed multiplier controller.
- Accepts one multiplicand/multiplier pair over a valid/ready handshake.
- Scans the multiplier two bits per cycle, recoding each overlapping triplet into a digit in {-2,-1,0,+1,+2}, and accumulates the shifted partial products.
- Presents the exact two's-complement product over a valid/ready output handshake. It is the sequenced, area-lean counterpart to the array-style partial-product cells in the fixed-point multiplier datapath.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4.
- CNT_W, $clog2(WIDTH/2)+1, digit-counter width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand, signed two's complement
- b  input  WIDTH  multiplier, signed two's complement
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  signed product a*b
- busy  output  1  high while in RUN

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0. Internal accumulator, operand registers and counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On an edge with in_valid=1: latch a as A, sign-extended to 2*WIDTH; latch {b,1'b0} as the scan register (appended bit is b[-1]=0); clear acc; set cnt=0; go to RUN.
- RUN
  - in_ready=0, busy=1.
  - Each cycle, decode triplet t = scan[2:0] = (b[2i+1], b[2i], b[2i-1]) with i=cnt:
    - 000, 111 -> 0
    - 001, 010 -> +A
    - 011 -> +2A
    - 100 -> -2A
    - 101, 110 -> -A
  - Negation is two's complement at 2*WIDTH bits. 2A is a left shift by 1 at 2*WIDTH bits.
  - acc <= acc + (pp << 2*cnt), modulo 2^(2*WIDTH).
  - scan <= scan >> 2 (arithmetic shift); cnt <= cnt+1.
  - After the edge processing cnt = WIDTH/2-1: go to DONE and load product <= final acc.
- DONE
  - out_valid=1, busy=0, in_ready=0.
  - product holds stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE; out_valid drops.
  - product keeps its value until the next DONE load.
- Latency:
  - out_valid rises exactly WIDTH/2 cycles after the accepting edge (4 for WIDTH=8).
  - Minimum issue interval is WIDTH/2+2 cycles.
- Handshake rules:
  - in_ready depends only on state, never combinationally on in_valid.
  - in_valid while not IDLE is ignored; the operands are not captured.
  - out_valid, once high, stays high until accepted.
- Arithmetic: result equals the exact signed product for all operand pairs, including a=b=-2^(WIDTH-1) (result 2^(2*WIDTH-2), representable).
- Simultaneous events: in DONE, in_valid=1 together with out_ready=1 returns to IDLE only. The new operands are accepted no earlier than the following edge.
- Reset mid-operation: an asynchronous return to the reset values above. Any partial result is discarded and no out_valid is produced.

Test Plan (WIDTH=8):
- Basic product: a=3, b=5, in_valid one cycle, out_ready=1 -> out_valid 4 cycles after acceptance, product=0x000F, busy high for exactly 4 cycles.
- Mixed signs: a=-7 (0xF9), b=6 -> product=0xFFD6 (-42). Then a=127, b=-128 -> product=0xC080 (-16256).
- Corner case: a=-128, b=-128 -> product=0x4000. Then a=0, b=-1 -> product=0x0000.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> product and out_valid held stable. Assert out_ready -> the next cycle is IDLE with in_ready=1. in_valid with new operands pulsed during RUN/DONE -> ignored, first result unchanged.
- Reset mid-run: drop rst_n during the 2nd RUN cycle -> all outputs immediately at reset values. After release, a=-1, b=-1 -> product=0x0001 with normal latency.
- Randomized self-check: 1000 random signed pairs with random out_ready stalls -> every product matches the reference a*b; exactly one out_valid handshake per accepted input.
